// File: rtl/menu_pkg.sv
// Shared types and defaults for menu screens: click-FSM state, colour defaults, button geometry.
package menu_pkg;

  typedef enum logic [0:0] {
    CLK_IDLE  = 1'b0,
    CLK_ARMED = 1'b1
  } click_state_t;

  localparam logic [11:0] KEY_RGB_DEF    = 12'h0FB;
  localparam logic [11:0] BG_RGB_DEF     = 12'h6AF;
  localparam logic [11:0] HILITE_RGB_DEF = 12'hFF0;

  function automatic int btn_top(input int y0, input int h, input int gap, input int k);
    return y0 + k * (h + gap);
  endfunction

endpackage

// File: rtl/cursor_ring.sv
// Cursor ring: a thin ring of radius R around (ctr_x, ctr_y), plus the axis spokes inside it.
// Purely combinational; usable by any screen that draws a mouse pointer.
module cursor_ring #(
  parameter int R = 30
) (
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  input  logic [9:0] ctr_x,
  input  logic [9:0] ctr_y,
  output logic       on
);

  localparam logic [21:0] RR    = 22'(R * R);
  localparam logic [21:0] RR_LO = (R * R >= 2) ? 22'(R * R - 2) : 22'd0;

  logic signed [10:0] dx, dy;
  logic [9:0]         ax, ay;
  logic [21:0]        ax_w, ay_w, d2;

  always_comb begin
    dx   = $signed({1'b0, draw_x}) - $signed({1'b0, ctr_x});
    dy   = $signed({1'b0, draw_y}) - $signed({1'b0, ctr_y});
    // |d| never exceeds 1023, so the magnitude fits in 10 bits
    ax   = dx[10] ? 10'(-dx) : dx[9:0];
    ay   = dy[10] ? 10'(-dy) : dy[9:0];
    ax_w = {12'd0, ax};
    ay_w = {12'd0, ay};
    d2   = ax_w * ax_w + ay_w * ay_w;
    on   = ((d2 >= RR_LO) && (d2 <= RR)) ||
           ((d2 <= RR) && ((dx == '0) || (dy == '0)));
  end

endmodule

// File: rtl/menu_screen.sv
// Title/menu screen: composes logo, stacked buttons and cursor; mouse click and key navigation select a button.
// RGB is registered one pixel_clk after DrawX/DrawY; no flow control, inputs are taken every cycle.
module menu_screen
  import menu_pkg::*;
#(
  parameter int          NUM_BTN    = 3,
  parameter int          BTN_X      = 245,
  parameter int          BTN_Y0     = 260,
  parameter int          BTN_W      = 150,
  parameter int          BTN_H      = 40,
  parameter int          BTN_GAP    = 10,
  parameter int          LOGO_X     = 120,
  parameter int          LOGO_Y     = 50,
  parameter int          LOGO_W     = 400,
  parameter int          LOGO_H     = 200,
  parameter int          CURSOR_R   = 30,
  parameter logic [11:0] KEY_RGB    = KEY_RGB_DEF,
  parameter logic [11:0] BG_RGB     = BG_RGB_DEF,
  parameter logic [11:0] HILITE_RGB = HILITE_RGB_DEF,
  localparam int         IW         = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
  input  logic          pixel_clk,
  input  logic          Reset_n,
  input  logic          blank,
  input  logic          frame_tick,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic [9:0]    mouseX,
  input  logic [9:0]    mouseY,
  input  logic [7:0]    mouseButton,
  input  logic          key_up,
  input  logic          key_down,
  input  logic          key_enter,
  input  logic          endgame,
  input  logic [3:0]    title_R,
  input  logic [3:0]    title_G,
  input  logic [3:0]    title_B,
  input  logic [3:0]    btn_R,
  input  logic [3:0]    btn_G,
  input  logic [3:0]    btn_B,
  output logic [IW-1:0] btn_idx,
  output logic [3:0]    Red,
  output logic [3:0]    Green,
  output logic [3:0]    Blue,
  output logic          start,
  output logic [IW-1:0] sel_idx,
  output logic          sel_valid,
  output logic [IW-1:0] focus_idx
);

  function automatic logic in_btn_x(input logic [9:0] x);
    int xi;
    xi = int'({22'd0, x});
    return (xi >= BTN_X) && (xi <= BTN_X + BTN_W);
  endfunction

  function automatic logic in_btn_y(input logic [9:0] y, input int k);
    int yi, top;
    yi  = int'({22'd0, y});
    top = btn_top(BTN_Y0, BTN_H, BTN_GAP, k);
    return (yi >= top) && (yi <= top + BTN_H);
  endfunction

  function automatic logic in_logo(input logic [9:0] x, input logic [9:0] y);
    int xi, yi;
    xi = int'({22'd0, x});
    yi = int'({22'd0, y});
    return (xi >= LOGO_X) && (xi < LOGO_X + LOGO_W) &&
           (yi >= LOGO_Y) && (yi < LOGO_Y + LOGO_H);
  endfunction

  click_state_t  state;
  logic [IW-1:0] arm_idx;
  logic [9:0]    mx_s, my_s;
  logic          btn_s;

  logic          draw_row_hit, mouse_hit;
  logic [IW-1:0] mouse_k;

  always_comb begin
    draw_row_hit = 1'b0;
    btn_idx      = '0;
    mouse_hit    = 1'b0;
    mouse_k      = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      if (in_btn_y(DrawY, k)) begin
        draw_row_hit = 1'b1;
        btn_idx      = IW'(k);
      end
      if (in_btn_x(mouseX) && in_btn_y(mouseY, k)) begin
        mouse_hit = 1'b1;
        mouse_k   = IW'(k);
      end
    end
  end

  // Pixel compositing
  logic        ring_on, on_btn;
  logic [11:0] title_rgb, btn_rgb, pix;

  cursor_ring #(.R(CURSOR_R)) u_ring (
    .draw_x (DrawX),
    .draw_y (DrawY),
    .ctr_x  (mx_s),
    .ctr_y  (my_s),
    .on     (ring_on)
  );

  always_comb begin
    title_rgb = {title_R, title_G, title_B};
    btn_rgb   = {btn_R, btn_G, btn_B};
    on_btn    = draw_row_hit && in_btn_x(DrawX);
    pix       = BG_RGB;
    if (!blank)
      pix = 12'h000;
    else if (ring_on)
      pix = 12'hFFF;
    else if (in_logo(DrawX, DrawY) && (title_rgb != KEY_RGB))
      pix = title_rgb;
    else if (on_btn && (btn_rgb != KEY_RGB))
      pix = btn_rgb;
    else if (on_btn && (btn_idx == focus_idx))
      pix = HILITE_RGB;
  end

  always_ff @(posedge pixel_clk) begin
    if (!Reset_n)
      {Red, Green, Blue} <= 12'h000;
    else
      {Red, Green, Blue} <= pix;
  end

  // Selection control
  logic          press, rel, idle, kup, kdn, kent, click_sel, req_sel, do_sel;
  logic [IW-1:0] req_k;

  always_comb begin
    press     = frame_tick && mouseButton[0] && !btn_s;
    rel       = frame_tick && !mouseButton[0] && btn_s;
    idle      = (state == CLK_IDLE);
    kup       = key_up && !key_down && idle;
    kdn       = key_down && !key_up && idle;
    kent      = key_enter && idle;
    click_sel = rel && !idle && mouse_hit && (mouse_k == arm_idx);
    req_sel   = click_sel || kent;
    req_k     = click_sel ? arm_idx : focus_idx;
    do_sel    = req_sel && !start && !endgame;
  end

  always_ff @(posedge pixel_clk) begin
    if (!Reset_n) begin
      state     <= CLK_IDLE;
      arm_idx   <= '0;
      mx_s      <= '0;
      my_s      <= '0;
      btn_s     <= 1'b0;
      focus_idx <= '0;
      sel_idx   <= '0;
      sel_valid <= 1'b0;
      start     <= 1'b0;
    end else begin
      sel_valid <= do_sel;
      if (do_sel)
        sel_idx <= req_k;

      if (frame_tick) begin
        mx_s  <= mouseX;
        my_s  <= mouseY;
        btn_s <= mouseButton[0];
      end

      // Keys are applied after hover so an explicit key press wins that cycle
      if (frame_tick && mouse_hit)
        focus_idx <= mouse_k;
      if (kdn)
        focus_idx <= (focus_idx == IW'(NUM_BTN - 1)) ? '0 : focus_idx + 1'b1;
      else if (kup)
        focus_idx <= (focus_idx == '0) ? IW'(NUM_BTN - 1) : focus_idx - 1'b1;

      if (endgame) begin
        state <= CLK_IDLE;
        start <= 1'b0;
      end else begin
        if (do_sel && (req_k == '0))
          start <= 1'b1;
        case (state)
          CLK_IDLE: begin
            if (press && mouse_hit) begin
              state   <= CLK_ARMED;
              arm_idx <= mouse_k;
            end
          end
          CLK_ARMED: begin
            if (rel)
              state <= CLK_IDLE;
          end
          default: state <= CLK_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_menu_screen.sv
// Directed bench for menu_screen: colour-priority vector table plus click/key/reset sequences.
module tb_menu_screen;

  logic       pixel_clk, Reset_n, blank, frame_tick;
  logic [9:0] DrawX, DrawY, mouseX, mouseY;
  logic [7:0] mouseButton;
  logic       key_up, key_down, key_enter, endgame;
  logic [3:0] title_R, title_G, title_B, btn_R, btn_G, btn_B;
  logic [1:0] btn_idx, sel_idx, focus_idx;
  logic [3:0] Red, Green, Blue;
  logic       start, sel_valid;

  int n_cmp = 0;
  int n_err = 0;

  menu_screen dut (
    .pixel_clk(pixel_clk), .Reset_n(Reset_n), .blank(blank), .frame_tick(frame_tick),
    .DrawX(DrawX), .DrawY(DrawY), .mouseX(mouseX), .mouseY(mouseY),
    .mouseButton(mouseButton), .key_up(key_up), .key_down(key_down),
    .key_enter(key_enter), .endgame(endgame),
    .title_R(title_R), .title_G(title_G), .title_B(title_B),
    .btn_R(btn_R), .btn_G(btn_G), .btn_B(btn_B),
    .btn_idx(btn_idx), .Red(Red), .Green(Green), .Blue(Blue),
    .start(start), .sel_idx(sel_idx), .sel_valid(sel_valid), .focus_idx(focus_idx)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic [11:0] title;
    logic [11:0] btn;
    logic [11:0] exp_rgb;
    logic        chk_idx;
    logic [1:0]  exp_idx;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic frame(input int x, input int y, input logic b);
    mouseX         = 10'(x);
    mouseY         = 10'(y);
    mouseButton[0] = b;
    frame_tick     = 1'b1;
    step();
    frame_tick     = 1'b0;
  endtask

  task automatic keys(input logic up, input logic dn, input logic ent, input logic eg);
    key_up = up; key_down = dn; key_enter = ent; endgame = eg;
    step();
    key_up = 0; key_down = 0; key_enter = 0; endgame = 0;
  endtask

  task automatic set_pix(input int x, input int y, input logic bl, input logic [11:0] t,
                         input logic [11:0] b);
    DrawX = 10'(x); DrawY = 10'(y); blank = bl;
    {title_R, title_G, title_B} = t;
    {btn_R, btn_G, btn_B} = b;
  endtask

  initial begin
    // x, y, blank, title, btn, expected rgb, check btn_idx, expected btn_idx
    vt[0]  = '{10'd130, 10'd100, 1'b1, 12'h123, 12'h456, 12'hFFF, 1'b0, 2'd0};
    vt[1]  = '{10'd130, 10'd100, 1'b0, 12'h123, 12'h456, 12'h000, 1'b0, 2'd0};
    vt[2]  = '{10'd200, 10'd100, 1'b1, 12'h123, 12'h456, 12'h123, 1'b0, 2'd0};
    vt[3]  = '{10'd200, 10'd100, 1'b1, 12'h0FB, 12'h456, 12'h6AF, 1'b0, 2'd0};
    vt[4]  = '{10'd300, 10'd280, 1'b1, 12'h123, 12'h456, 12'h456, 1'b1, 2'd0};
    vt[5]  = '{10'd300, 10'd280, 1'b1, 12'h123, 12'h0FB, 12'hFF0, 1'b1, 2'd0};
    vt[6]  = '{10'd300, 10'd330, 1'b1, 12'h123, 12'h0FB, 12'h6AF, 1'b1, 2'd1};
    vt[7]  = '{10'd300, 10'd330, 1'b1, 12'h123, 12'h789, 12'h789, 1'b1, 2'd1};
    vt[8]  = '{10'd245, 10'd300, 1'b1, 12'h123, 12'h0FB, 12'hFF0, 1'b1, 2'd0};
    vt[9]  = '{10'd395, 10'd380, 1'b1, 12'h123, 12'h0FB, 12'h6AF, 1'b1, 2'd2};
    vt[10] = '{10'd396, 10'd280, 1'b1, 12'h123, 12'h456, 12'h6AF, 1'b1, 2'd0};
    vt[11] = '{10'd300, 10'd305, 1'b1, 12'h123, 12'h456, 12'h6AF, 1'b0, 2'd0};
    vt[12] = '{10'd100, 10'd100, 1'b1, 12'h123, 12'h456, 12'hFFF, 1'b0, 2'd0};
    vt[13] = '{10'd118, 10'd124, 1'b1, 12'h123, 12'h456, 12'hFFF, 1'b0, 2'd0};
    vt[14] = '{10'd118, 10'd123, 1'b1, 12'h123, 12'h456, 12'h6AF, 1'b0, 2'd0};

    Reset_n = 1'b0; frame_tick = 1'b0; mouseButton = 8'h00;
    mouseX = '0; mouseY = '0;
    key_up = 0; key_down = 0; key_enter = 0; endgame = 0;
    set_pix(200, 100, 1'b1, 12'h123, 12'h456);
    step(); step();
    chk("rst_start", start, 0);
    chk("rst_sel_valid", sel_valid, 0);
    chk("rst_sel_idx", sel_idx, 0);
    chk("rst_focus", focus_idx, 0);
    chk("rst_rgb", {Red, Green, Blue}, 12'h000);
    Reset_n = 1'b1;

    // Click on button 0 and release on it
    frame(320, 280, 1'b1);
    chk("click0_press_no_sel", sel_valid, 0);
    frame(320, 280, 1'b0);
    chk("click0_sel_valid", sel_valid, 1);
    chk("click0_sel_idx", sel_idx, 0);
    chk("click0_start", start, 1);
    step();
    chk("click0_pulse_len", sel_valid, 0);
    keys(0, 0, 0, 1);
    chk("endgame_clears_start", start, 0);

    // Press on button 0, release on button 1
    frame(320, 280, 1'b1);
    frame(320, 330, 1'b0);
    chk("drag_off_no_sel", sel_valid, 0);
    chk("drag_off_start", start, 0);
    chk("drag_off_hover_focus", focus_idx, 1);
    keys(0, 0, 1, 0);
    chk("drag_off_idle_enter", sel_valid, 1);
    chk("drag_off_enter_idx", sel_idx, 1);

    // Keyboard navigation with the mouse parked off the buttons
    frame(0, 0, 1'b0);
    keys(0, 1, 0, 0);
    chk("kdown_1_2", focus_idx, 2);
    keys(0, 1, 0, 0);
    chk("kdown_wrap", focus_idx, 0);
    keys(1, 0, 0, 0);
    chk("kup_wrap", focus_idx, 2);
    keys(1, 1, 0, 0);
    chk("kboth_ignored", focus_idx, 2);
    keys(0, 0, 1, 0);
    chk("kenter2_valid", sel_valid, 1);
    chk("kenter2_idx", sel_idx, 2);
    chk("kenter2_start", start, 0);

    // Keys ignored while armed
    frame(320, 280, 1'b1);
    chk("armed_hover_focus", focus_idx, 0);
    keys(0, 1, 0, 0);
    chk("armed_kdown_ignored", focus_idx, 0);
    keys(0, 0, 1, 0);
    chk("armed_enter_ignored", sel_valid, 0);
    frame(0, 0, 1'b0);
    chk("armed_rel_outside", sel_valid, 0);

    // Endgame priority
    keys(0, 0, 1, 1);
    chk("eg_beats_sel_valid", sel_valid, 0);
    chk("eg_beats_sel_start", start, 0);
    keys(0, 0, 1, 0);
    chk("enter0_start", start, 1);
    chk("enter0_valid", sel_valid, 1);
    keys(0, 0, 1, 1);
    chk("eg_enter_start", start, 0);
    chk("eg_enter_valid", sel_valid, 0);

    // Colour table with the cursor sampled at (100,100), focus on button 0
    frame(100, 100, 1'b0);
    for (int i = 0; i < 15; i++) begin
      set_pix(int'(vt[i].x), int'(vt[i].y), vt[i].blank, vt[i].title, vt[i].btn);
      #1;
      if (vt[i].chk_idx)
        chk($sformatf("vec%0d_btn_idx", i), btn_idx, vt[i].exp_idx);
      step();
      chk($sformatf("vec%0d_rgb", i), {Red, Green, Blue}, vt[i].exp_rgb);
    end

    // Reset in the middle of a click
    set_pix(200, 100, 1'b1, 12'h123, 12'h456);
    keys(0, 1, 0, 0);
    keys(0, 0, 1, 0);
    chk("pre_rst_sel_idx", sel_idx, 1);
    chk("pre_rst_rgb", {Red, Green, Blue}, 12'h123);
    frame(320, 330, 1'b1);
    Reset_n = 1'b0;
    step();
    chk("midrst_start", start, 0);
    chk("midrst_sel_valid", sel_valid, 0);
    chk("midrst_sel_idx", sel_idx, 0);
    chk("midrst_focus", focus_idx, 0);
    chk("midrst_rgb", {Red, Green, Blue}, 12'h000);
    Reset_n = 1'b1;
    frame(320, 330, 1'b0);
    chk("midrst_rel_no_sel", sel_valid, 0);
    chk("midrst_hover", focus_idx, 1);
    keys(0, 0, 1, 0);
    chk("midrst_idle_enter", sel_valid, 1);
    chk("midrst_enter_idx", sel_idx, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
